// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file arbiter slice: default widths,
// FSM state encoding and requester ids.
package regfile_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/regfile_arbiter_if.sv
// Requester A/B handshakes plus register-file pins shared by the arbiter.
// slave = arbiter side, master = requesters and register file.
interface regfile_arbiter_if #(
  parameter int DATA_W = regfile_pkg::DATA_W_DEF,
  parameter int ADDR_W = regfile_pkg::ADDR_W_DEF
);

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_done;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_done;
  logic [DATA_W-1:0] b_rdata;

  logic [ADDR_W-1:0] rf_addr1;
  logic [ADDR_W-1:0] rf_addr2;
  logic [ADDR_W-1:0] rf_addrw;
  logic              rf_write;
  logic [DATA_W-1:0] rf_data_in;
  logic [DATA_W-1:0] rf_out1;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  rf_out1,
    output a_gnt, a_done, a_rdata,
    output b_gnt, b_done, b_rdata,
    output rf_addr1, rf_addr2, rf_addrw, rf_write, rf_data_in
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output rf_out1,
    input  a_gnt, a_done, a_rdata,
    input  b_gnt, b_done, b_rdata,
    input  rf_addr1, rf_addr2, rf_addrw, rf_write, rf_data_in
  );

endinterface

// File: rtl/regfile_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; the caller owns last_grant.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       sel
);

  always_comb begin
    sel = REQ_A;
    if (&req) begin
      sel = ~last;
    end else if (req[1]) begin
      sel = REQ_B;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin sequencer sharing one register-file access slot between A and B.
// Optional: define REGFILE_ARB_R0_PROTECT_EN to suppress writes to register 0.
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  regfile_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic              rd_q, rd_d;
  logic              a_gnt_q, a_gnt_d;
  logic              b_gnt_q, b_gnt_d;
  logic              a_done_q, a_done_d;
  logic              b_done_q, b_done_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic              rf_write_q, rf_write_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;

  logic              sel;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              r0_block;

  rr_arb2 u_rr_arb2 (
    .req  ({bus.b_req, bus.a_req}),
    .last (last_q),
    .sel  (sel)
  );

  always_comb begin
    win_we    = bus.a_we;
    win_addr  = bus.a_addr;
    win_wdata = bus.a_wdata;
    if (sel == REQ_B) begin
      win_we    = bus.b_we;
      win_addr  = bus.b_addr;
      win_wdata = bus.b_wdata;
    end
  end

`ifdef REGFILE_ARB_R0_PROTECT_EN
  assign r0_block = (win_addr == '0);
`else
  assign r0_block = 1'b0;
`endif

  // The latched address and write data live directly in the rf_* output
  // registers, so only the owner and the read/write flag are held separately.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    rd_d       = rd_q;
    a_gnt_d    = 1'b0;
    b_gnt_d    = 1'b0;
    a_done_d   = 1'b0;
    b_done_d   = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    rf_addr_d  = '0;
    rf_write_d = 1'b0;
    rf_data_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.a_req || bus.b_req) begin
          state_d    = ST_ACCESS;
          owner_d    = sel;
          last_d     = sel;
          rd_d       = !win_we;
          a_gnt_d    = (sel == REQ_A);
          b_gnt_d    = (sel == REQ_B);
          rf_addr_d  = win_addr;
          rf_write_d = win_we && !r0_block;
          rf_data_d  = win_we ? win_wdata : '0;
        end
      end
      ST_ACCESS: begin
        state_d  = ST_DONE;
        a_done_d = (owner_q == REQ_A);
        b_done_d = (owner_q == REQ_B);
        if (rd_q && owner_q == REQ_A) a_rdata_d = bus.rf_out1;
        if (rd_q && owner_q == REQ_B) b_rdata_d = bus.rf_out1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_q     <= REQ_B;
      owner_q    <= REQ_A;
      rd_q       <= 1'b0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_done_q   <= 1'b0;
      b_done_q   <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      rf_addr_q  <= '0;
      rf_write_q <= 1'b0;
      rf_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      rd_q       <= rd_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      a_done_q   <= a_done_d;
      b_done_q   <= b_done_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      rf_addr_q  <= rf_addr_d;
      rf_write_q <= rf_write_d;
      rf_data_q  <= rf_data_d;
    end
  end

  assign bus.a_gnt      = a_gnt_q;
  assign bus.b_gnt      = b_gnt_q;
  assign bus.a_done     = a_done_q;
  assign bus.b_done     = b_done_q;
  assign bus.a_rdata    = a_rdata_q;
  assign bus.b_rdata    = b_rdata_q;
  assign bus.rf_addr1   = rf_addr_q;
  assign bus.rf_addr2   = rf_addr_q;
  assign bus.rf_addrw   = rf_addr_q;
  assign bus.rf_write   = rf_write_q;
  assign bus.rf_data_in = rf_data_q;

endmodule
